// File: rtl/muldiv_seq_ctrl.sv
// Issue/sequencing controller for the multi-cycle multiply/divide unit in EX.
// It launches the datapath, holds the pipeline while the unit runs and emits a single writeback pulse.
module muldiv_seq_ctrl #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Valid,
    input  logic [6:0] Opcode,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic [4:0] Rd,
    input  logic       DivisorZero,
    input  logic       Flush,
    output logic       Start,
    output logic [2:0] MulDivOp,
    output logic [4:0] MulDivRd,
    output logic       Stall,
    output logic       Busy,
    output logic       RegWrite,
    output logic       DivByZero
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [5:0] MUL_CNT   = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT   = 6'(DIV_LAT - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic [4:0] rd_q, rd_d;
    logic       dbz_q, dbz_d;
    logic       issue;

    // rst_n gates issue so the combinational Start/Stall paths are also quiet during reset.
    assign issue = rst_n && Valid && (Opcode == OPC_OP) && (Funct7 == F7_MULDIV)
                   && (state_q == IDLE) && !Flush;

    assign Busy     = (state_q == MUL_BUSY) || (state_q == DIV_BUSY);
    assign Stall    = issue || Busy;
    assign MulDivOp = op_q;
    assign MulDivRd = rd_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        dbz_d     = dbz_q;
        Start     = 1'b0;
        RegWrite  = 1'b0;
        DivByZero = 1'b0;

        if (Flush) begin
            state_d = IDLE;
            dbz_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        Start = 1'b1;
                        op_d  = Funct3;
                        rd_d  = Rd;
                        if (!Funct3[2]) begin
                            cnt_d   = MUL_CNT;
                            dbz_d   = 1'b0;
                            state_d = MUL_BUSY;
                        end else if (DivisorZero) begin
                            // A zero divisor has a fixed architectural result, so skip the datapath.
                            dbz_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d   = DIV_CNT;
                            dbz_d   = 1'b0;
                            state_d = DIV_BUSY;
                        end
                    end
                end
                MUL_BUSY, DIV_BUSY: begin
                    if (cnt_q == 6'd0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                DONE: begin
                    RegWrite  = 1'b1;
                    DivByZero = dbz_q;
                    dbz_d     = 1'b0;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 3'd0;
            rd_q    <= 5'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: two instances (slow and fast latencies) share one stimulus
// stream and are compared every cycle against a cycle-number based model of each outstanding op.
module tb_muldiv_seq_ctrl;

    localparam int MUL_LAT_A = 4;
    localparam int DIV_LAT_A = 33;
    localparam int MUL_LAT_B = 1;
    localparam int DIV_LAT_B = 5;
    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] F7_M   = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [6:0] funct7 = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [4:0] rd = 5'd0;
    logic       divisorZero = 1'b0;
    logic       flush = 1'b0;

    logic [1:0] startW, stallW, busyW, regWriteW, dbzW;
    logic [2:0] opW [2];
    logic [4:0] rdW [2];

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    muldiv_seq_ctrl #(.BITS(32), .MUL_LAT(MUL_LAT_A), .DIV_LAT(DIV_LAT_A)) u_dutA (
        .clk(clk), .rst_n(rst_n), .Valid(valid), .Opcode(opcode), .Funct7(funct7),
        .Funct3(funct3), .Rd(rd), .DivisorZero(divisorZero), .Flush(flush),
        .Start(startW[0]), .MulDivOp(opW[0]), .MulDivRd(rdW[0]), .Stall(stallW[0]),
        .Busy(busyW[0]), .RegWrite(regWriteW[0]), .DivByZero(dbzW[0])
    );

    muldiv_seq_ctrl #(.BITS(32), .MUL_LAT(MUL_LAT_B), .DIV_LAT(DIV_LAT_B)) u_dutB (
        .clk(clk), .rst_n(rst_n), .Valid(valid), .Opcode(opcode), .Funct7(funct7),
        .Funct3(funct3), .Rd(rd), .DivisorZero(divisorZero), .Flush(flush),
        .Start(startW[1]), .MulDivOp(opW[1]), .MulDivRd(rdW[1]), .Stall(stallW[1]),
        .Busy(busyW[1]), .RegWrite(regWriteW[1]), .DivByZero(dbzW[1])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: one outstanding op per instance, described by its issue and completion cycles.
    int         curCycle = 0;
    bit         haveOp [2];
    int         opIssue [2];
    int         opDone [2];
    bit         opDbz [2];
    logic [2:0] heldOp [2];
    logic [4:0] heldRd [2];

    function automatic int latencyOf(input int k, input bit isDiv);
        if (k == 0) return isDiv ? DIV_LAT_A : MUL_LAT_A;
        return isDiv ? DIV_LAT_B : MUL_LAT_B;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                bit isM, expStart, expBusy, expRw, expDbz, expStall, isDiv;
                if (!rst_n) begin
                    haveOp[k] = 1'b0;
                    heldOp[k] = 3'd0;
                    heldRd[k] = 5'd0;
                end
                isM      = valid && (opcode == OPC_OP) && (funct7 == F7_M);
                expStart = rst_n && isM && !haveOp[k] && !flush;
                expBusy  = haveOp[k] && (curCycle > opIssue[k]) && (curCycle < opDone[k]);
                expRw    = haveOp[k] && (curCycle == opDone[k]) && !flush;
                expDbz   = expRw && opDbz[k];
                expStall = expStart || expBusy;

                checkOutput($sformatf("start[%0d]", k), int'(startW[k]), int'(expStart));
                checkOutput($sformatf("stall[%0d]", k), int'(stallW[k]), int'(expStall));
                checkOutput($sformatf("busy[%0d]", k), int'(busyW[k]), int'(expBusy));
                checkOutput($sformatf("regwrite[%0d]", k), int'(regWriteW[k]), int'(expRw));
                checkOutput($sformatf("divbyzero[%0d]", k), int'(dbzW[k]), int'(expDbz));
                checkOutput($sformatf("muldivop[%0d]", k), int'(opW[k]), int'(heldOp[k]));
                checkOutput($sformatf("muldivrd[%0d]", k), int'(rdW[k]), int'(heldRd[k]));

                if (expStart) begin
                    isDiv      = funct3[2];
                    haveOp[k]  = 1'b1;
                    opIssue[k] = curCycle;
                    opDbz[k]   = isDiv && divisorZero;
                    opDone[k]  = curCycle + (opDbz[k] ? 1 : latencyOf(k, isDiv) + 1);
                    heldOp[k]  = funct3;
                    heldRd[k]  = rd;
                end else if (haveOp[k] && (flush || curCycle == opDone[k])) begin
                    haveOp[k] = 1'b0;
                end
            end
        end
        curCycle++;
    end

    task automatic applyStimulus(input bit v, input logic [6:0] opc, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic [4:0] r, input bit dz, input bit fl);
        @(posedge clk);
        #1;
        valid       = v;
        opcode      = opc;
        funct7      = f7;
        funct3      = f3;
        rd          = r;
        divisorZero = dz;
        flush       = fl;
    endtask

    task automatic issueM(input logic [2:0] f3, input logic [4:0] r, input bit dz);
        applyStimulus(1'b1, OPC_OP, F7_M, f3, r, dz, 1'b0);
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 7'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset stall", int'(stallW[0]), 0);
        checkOutput("reset op", int'(opW[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) bubble();

        // MUL, rd=5, MUL_LAT=4
        issueM(3'b000, 5'd5, 1'b0);
        @(negedge clk);
        checkOutput("mul start c0", int'(startW[0]), 1);
        checkOutput("mul stall c0", int'(stallW[0]), 1);
        for (int i = 1; i <= 6; i++) begin
            bubble();
            @(negedge clk);
            checkOutput($sformatf("mul start c%0d", i), int'(startW[0]), 0);
            checkOutput($sformatf("mul stall c%0d", i), int'(stallW[0]), (i <= 4) ? 1 : 0);
            checkOutput($sformatf("mul regwrite c%0d", i), int'(regWriteW[0]), (i == 5) ? 1 : 0);
            if (i == 5) checkOutput("mul rd c5", int'(rdW[0]), 5);
        end
        repeat (3) bubble();

        // DIVU, DIV_LAT=33
        issueM(3'b101, 5'd7, 1'b0);
        for (int i = 1; i <= 35; i++) begin
            bubble();
            @(negedge clk);
            checkOutput($sformatf("divu busy c%0d", i), int'(busyW[0]), (i <= 33) ? 1 : 0);
            checkOutput($sformatf("divu regwrite c%0d", i), int'(regWriteW[0]), (i == 34) ? 1 : 0);
            if (i == 34) checkOutput("divu dbz c34", int'(dbzW[0]), 0);
        end

        // REM with zero divisor
        issueM(3'b110, 5'd9, 1'b1);
        @(negedge clk);
        checkOutput("rem0 stall c0", int'(stallW[0]), 1);
        bubble();
        @(negedge clk);
        checkOutput("rem0 stall c1", int'(stallW[0]), 0);
        checkOutput("rem0 regwrite c1", int'(regWriteW[0]), 1);
        checkOutput("rem0 dbz c1", int'(dbzW[0]), 1);
        checkOutput("rem0 op c1", int'(opW[0]), 6);
        bubble();

        // DIV flushed at cycle 3
        issueM(3'b100, 5'd3, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) applyStimulus(1'b0, 7'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b1);
            else bubble();
            @(negedge clk);
            if (i == 4) checkOutput("flush busy c4", int'(busyW[0]), 0);
            checkOutput($sformatf("flush regwrite c%0d", i), int'(regWriteW[0]), 0);
        end

        // ADD / SUB never engage the unit
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, OPC_OP, (i % 2 == 1) ? 7'b0100000 : 7'b0000000, 3'b000, 5'd4, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("addsub start", int'(startW[0]), 0);
            checkOutput("addsub stall", int'(stallW[0]), 0);
            checkOutput("addsub regwrite", int'(regWriteW[0]), 0);
        end

        // Reset in the middle of a DIV, then a MUL on the MUL_LAT=1 instance
        issueM(3'b100, 5'd11, 1'b0);
        for (int i = 1; i <= 9; i++) bubble();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst busy", int'(busyW[0]), 0);
        checkOutput("rst stall", int'(stallW[0]), 0);
        checkOutput("rst rd", int'(rdW[0]), 0);
        checkOutput("rst op", int'(opW[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issueM(3'b000, 5'd13, 1'b0);
        @(negedge clk);
        checkOutput("post-rst startB", int'(startW[1]), 1);
        bubble();
        @(negedge clk);
        checkOutput("post-rst busyB c1", int'(busyW[1]), 1);
        checkOutput("post-rst regwriteB c1", int'(regWriteW[1]), 0);
        bubble();
        @(negedge clk);
        checkOutput("post-rst regwriteB c2", int'(regWriteW[1]), 1);
        checkOutput("post-rst rdB c2", int'(rdW[1]), 13);
        repeat (40) bubble();

        // Randomized traffic, including flushes and occasional resets
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            rst_n       = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            valid       = ($urandom_range(0, 9) != 0);
            opcode      = ($urandom_range(0, 9) < 8) ? OPC_OP : 7'($urandom_range(0, 127));
            funct7      = ($urandom_range(0, 9) < 8) ? F7_M : 7'($urandom_range(0, 127));
            funct3      = 3'($urandom_range(0, 7));
            rd          = 5'($urandom_range(0, 31));
            divisorZero = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 99) < 5);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) bubble();
        @(negedge clk);
        checkEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
MULDIV_SEQ_CTRL -- requirements
Module: muldiv_seq_ctrl

Interface
REQ-001 Parameter BITS, default 32, datapath width passed through to the multiply/divide unit.
REQ-002 Parameter MUL_LAT, default 4, busy cycles for MUL/MULH/MULHSU/MULHU (Funct3[2]=0); legal range 1..63.
REQ-003 Parameter DIV_LAT, default 33, busy cycles for DIV/DIVU/REM/REMU (Funct3[2]=1); legal range 1..63.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 Valid  input  1  instruction in EX is valid.
REQ-007 Opcode  input  7  EX instruction opcode.
REQ-008 Funct7  input  7  EX instruction funct7.
REQ-009 Funct3  input  3  EX instruction funct3.
REQ-010 Rd  input  5  EX destination register.
REQ-011 DivisorZero  input  1  rs2 operand equals zero, sampled in the issue cycle.
REQ-012 Flush  input  1  kill the EX instruction, including any in-flight mul/div.
REQ-013 Start  output  1  one-cycle pulse launching the mul/div datapath.
REQ-014 MulDivOp  output  3  latched Funct3 of the in-flight operation.
REQ-015 MulDivRd  output  5  latched Rd of the in-flight operation.
REQ-016 Stall  output  1  freeze IF/ID/EX while high.
REQ-017 Busy  output  1  high in MUL_BUSY and DIV_BUSY.
REQ-018 RegWrite  output  1  one-cycle mul/div writeback enable.
REQ-019 DivByZero  output  1  high with RegWrite when the completed op was a division with zero divisor.

Function
REQ-020 Issue condition: Valid=1, Opcode=7'b0110011, Funct7=7'b0000001, state IDLE, Flush=0.
REQ-021 States: IDLE, MUL_BUSY, DIV_BUSY, DONE; 6-bit down-counter cnt.
REQ-022 IDLE on issue: Start=1; latch Funct3 into MulDivOp and Rd into MulDivRd.
REQ-023 IDLE on issue with Funct3[2]=0: cnt<=MUL_LAT-1, next state MUL_BUSY.
REQ-024 IDLE on issue with Funct3[2]=1 and DivisorZero=0: cnt<=DIV_LAT-1, next state DIV_BUSY.
REQ-025 IDLE on issue with Funct3[2]=1 and DivisorZero=1: set DivByZero flag, next state DONE.
REQ-026 MUL_BUSY/DIV_BUSY: cnt decrements each cycle; when cnt=0, next state DONE.
REQ-027 Normal latency: DONE is reached LAT+1 cycles after the issue cycle; divide-by-zero DONE is reached 1 cycle after issue.
REQ-028 Stall = issue condition (combinational, in IDLE) OR Busy; Stall is 0 in DONE.
REQ-029 DONE: RegWrite=1 for exactly one cycle; next state IDLE unconditionally; decode is ignored in DONE so the retiring instruction is not re-issued.
REQ-030 Flush in any state forces next state IDLE; it suppresses Start and RegWrite that cycle and clears the DivByZero flag.
REQ-031 Flush has priority over issue and over DONE.
REQ-032 Non-M instructions, Valid=0, or an M opcode with Funct7 other than 0000001 never cause Start, Stall, or RegWrite.
REQ-033 MulDivOp and MulDivRd hold their values from issue through DONE.

Reset
REQ-034 rst_n=0 immediately forces IDLE, cnt=0, MulDivOp=0, MulDivRd=0, DivByZero flag=0.
REQ-035 Reset forces Start, Stall, Busy, RegWrite, and DivByZero to 0, including mid-operation.
REQ-036 No RegWrite is issued for an operation interrupted by reset.

Verification
REQ-037 MUL (Funct3=000, Rd=5), MUL_LAT=4, issue at cycle 0 -> Start at cycle 0 only; Stall high cycles 0-4; RegWrite=1, MulDivRd=5 at cycle 5; IDLE at cycle 6.
REQ-038 DIVU (Funct3=101), DIV_LAT=33, DivisorZero=0, issue at cycle 0 -> Busy cycles 1-33; RegWrite at cycle 34; DivByZero=0.
REQ-039 REM (Funct3=110) with DivisorZero=1 at cycle 0 -> Stall at cycle 0 only; RegWrite=1 and DivByZero=1 at cycle 1.
REQ-040 DIV issued at cycle 0, Flush=1 at cycle 3 -> IDLE at cycle 4; no RegWrite through cycle 40.
REQ-041 ADD (Funct7=0000000) and SUB (Funct7=0100000) with Valid=1 -> Start=0, Stall=0, RegWrite=0 on every cycle.
REQ-042 rst_n pulled low at cycle 10 of a DIV -> all outputs 0 asynchronously; after release a MUL issues normally with MUL_LAT=1 and RegWrite at issue+2.
